// File: rtl/bcd_mmss_pkg.sv
// Shared definitions for the MM:SS counter/display block: active-low
// segment codes, BCD digit limits, digit-index and run-state types, and
// small digit helpers used by the counter chain.
package bcd_mmss_pkg;

   // Active-low segment codes {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [3:0] ONES_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX = 4'd5;

   typedef logic [1:0] digit_idx_t;

   typedef enum logic {
      RUN_STOPPED = 1'b0,
      RUN_ACTIVE  = 1'b1
   } run_state_t;

   // Digit positions 1 and 3 are tens digits (0-5), 0 and 2 are ones (0-9)
   function automatic logic [3:0] digit_max(input int unsigned pos);
      return ((pos % 2) == 1) ? TENS_MAX : ONES_MAX;
   endfunction

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
      return (d > max) ? max : d;
   endfunction

   // One BCD step with wrap at the digit's range ends
   function automatic logic [3:0] step_digit(input logic [3:0] d, input logic [3:0] max,
                                             input logic down);
      if (down) return (d == 4'd0) ? max : d - 4'd1;
      else      return (d == max)  ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/bcd_mmss_display_seg7_bcd_decode.sv
// seg7_bcd_decode: combinational BCD digit to active-low 7-segment code.
// Ports:
//   digit - 4-bit BCD input
//   seg   - {g,f,e,d,c,b,a}, active-low; codes 10-15 give all segments off
module seg7_bcd_decode
   import bcd_mmss_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK[6:0];
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK[6:0];
      endcase
   end

endmodule

// File: rtl/bcd_mmss_display.sv
// bcd_mmss_display: four-digit MM:SS up/down counter with run/stop toggle,
// clamped BCD preset, terminal-count pulse and a scanned common-anode
// 7-segment driver (segments and anodes active-low).
// Ports:
//   CLK      - clock
//   RESET    - synchronous active-high reset
//   DEC      - 1 = count down, 0 = count up
//   START    - one-cycle pulse, toggles run state
//   LOAD     - one-cycle pulse, presets count from LOAD_VAL
//   LOAD_VAL - BCD {min_tens, min_ones, sec_tens, sec_ones}
//   RUN      - registered run state
//   TC       - one-cycle terminal-count pulse
//   COUNT    - current BCD count, same packing as LOAD_VAL
//   LED      - {dp,g,f,e,d,c,b,a}, active-low
//   SA       - one-hot anode select, active-low, SA[0] = sec_ones
module bcd_mmss_display
   import bcd_mmss_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 100_000_000,
   parameter int unsigned SCAN_DIV  = 4096,
   parameter bit          WRAP_DOWN = 1'b1,
   parameter bit          BLANK_LZ  = 1'b0
)(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        DEC,
   input  logic        START,
   input  logic        LOAD,
   input  logic [15:0] LOAD_VAL,
   output logic        RUN,
   output logic        TC,
   output logic [15:0] COUNT,
   output logic [7:0]  LED,
   output logic [3:0]  SA
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned SW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   logic [15:0]   count_q, count_n;
   logic [PW-1:0] presc_q, presc_n;
   run_state_t    run_q, run_n;
   logic          tc_q, tc_n;
   logic [SW-1:0] scan_q, scan_n;
   digit_idx_t    idx_q, idx_n;
   logic [7:0]    led_q, led_n;
   logic [3:0]    sa_q, sa_n;

   logic [3:0] dig [4];
   logic [3:0] at_limit;
   logic [3:0] adv;
   logic       step, wrap, hold_zero;
   logic [3:0] sel_digit;
   logic [6:0] sel_seg;

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         dig[i] = count_q[4*i +: 4];
      end
   end

   // A digit is at its limit when the next step in the current direction wraps it
   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         at_limit[i] = DEC ? (dig[i] == 4'd0) : (dig[i] == digit_max(i));
      end
   end

   // Ripple chain: a digit advances when every lower digit wraps
   assign adv[0]    = 1'b1;
   assign adv[1]    = at_limit[0];
   assign adv[2]    = &at_limit[1:0];
   assign adv[3]    = &at_limit[2:0];
   assign wrap      = &at_limit;
   assign step      = (run_q == RUN_ACTIVE) && (presc_q == TICK_LAST);
   // Non-wrapping down count freezes at 00:00 and drops out of run
   assign hold_zero = DEC && wrap && !WRAP_DOWN;

   always_comb begin
      count_n = count_q;
      presc_n = presc_q;
      run_n   = run_q;
      tc_n    = 1'b0;

      if (START) begin
         run_n = (run_q == RUN_ACTIVE) ? RUN_STOPPED : RUN_ACTIVE;
      end

      if (LOAD) begin
         count_n = {clamp_digit(LOAD_VAL[15:12], TENS_MAX),
                    clamp_digit(LOAD_VAL[11:8],  ONES_MAX),
                    clamp_digit(LOAD_VAL[7:4],   TENS_MAX),
                    clamp_digit(LOAD_VAL[3:0],   ONES_MAX)};
         presc_n = '0;
      end else if (step) begin
         presc_n = '0;
         tc_n    = wrap;
         if (hold_zero) begin
            run_n = RUN_STOPPED;
         end else begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (adv[i]) count_n[4*i +: 4] = step_digit(dig[i], digit_max(i), DEC);
            end
         end
      end else if (run_q == RUN_ACTIVE) begin
         presc_n = presc_q + PW'(1);
      end else begin
         presc_n = '0;
      end

      // Leaving run always parks the prescaler so a restart gets a full period
      if (run_n == RUN_STOPPED) presc_n = '0;
   end

   // Scan divider and digit index, free-running
   always_comb begin
      scan_n = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
      idx_n  = (scan_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
   end

   assign sel_digit = dig[idx_q];

   seg7_bcd_decode u_decode (
      .digit (sel_digit),
      .seg   (sel_seg)
   );

   // Colon dp is lit only beside min_ones (index 2)
   always_comb begin
      sa_n = ~(4'b0001 << idx_q);
      if (BLANK_LZ && (idx_q == 2'd3) && (dig[3] == 4'd0)) led_n = SEG_BLANK;
      else                                                  led_n = {(idx_q != 2'd2), sel_seg};
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count_q <= '0;
         presc_q <= '0;
         run_q   <= RUN_STOPPED;
         tc_q    <= 1'b0;
         scan_q  <= '0;
         idx_q   <= '0;
         led_q   <= {1'b1, SEG_0};
         sa_q    <= 4'b1110;
      end else begin
         count_q <= count_n;
         presc_q <= presc_n;
         run_q   <= run_n;
         tc_q    <= tc_n;
         scan_q  <= scan_n;
         idx_q   <= idx_n;
         led_q   <= led_n;
         sa_q    <= sa_n;
      end
   end

   assign COUNT = count_q;
   assign RUN   = (run_q == RUN_ACTIVE);
   assign TC    = tc_q;
   assign LED   = led_q;
   assign SA    = sa_q;

endmodule

// File: tb/tb_bcd_mmss_display.sv
module tb_bcd_mmss_display;

   logic        clk = 1'b0;
   logic        reset, dec, start, load;
   logic [15:0] load_val;

   logic        run_a, tc_a, run_b, tc_b;
   logic [15:0] count_a, count_b;
   logic [7:0]  led_a, led_b;
   logic [3:0]  sa_a, sa_b;

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;
   logic [15:0] sb_q [$];

   always #5 clk = ~clk;

   // a: wrapping down-count, no blanking; b: stop at 00:00, leading-zero blanking
   bcd_mmss_display #(.TICK_DIV(4), .SCAN_DIV(2), .WRAP_DOWN(1'b1), .BLANK_LZ(1'b0)) dut_a (
      .CLK(clk), .RESET(reset), .DEC(dec), .START(start), .LOAD(load), .LOAD_VAL(load_val),
      .RUN(run_a), .TC(tc_a), .COUNT(count_a), .LED(led_a), .SA(sa_a)
   );

   bcd_mmss_display #(.TICK_DIV(4), .SCAN_DIV(2), .WRAP_DOWN(1'b0), .BLANK_LZ(1'b1)) dut_b (
      .CLK(clk), .RESET(reset), .DEC(dec), .START(start), .LOAD(load), .LOAD_VAL(load_val),
      .RUN(run_b), .TC(tc_b), .COUNT(count_b), .LED(led_b), .SA(sa_b)
   );

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [15:0] v);
      sb_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [15:0] obs);
      logic [15:0] exp;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_err++;
         $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
      end else begin
         exp = sb_q.pop_front();
         assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int unsigned ticks;
      logic [15:0] sa;
      logic [15:0] led_a;
      logic [15:0] led_b;
   } scan_step_t;

   scan_step_t scan_tbl [4];

   initial begin
      scan_tbl[0] = '{1, 16'h000D, 16'h00A4, 16'h00A4};
      scan_tbl[1] = '{2, 16'h000B, 16'h0079, 16'h0079};
      scan_tbl[2] = '{2, 16'h0007, 16'h00C0, 16'h00FF};
      scan_tbl[3] = '{2, 16'h000E, 16'h00B0, 16'h00B0};

      reset = 1'b1; dec = 1'b0; start = 1'b0; load = 1'b0; load_val = '0;
      tick(3);
      push(16'h0000); check("reset_count", count_a);
      push(16'h0000); check("reset_run",   16'(run_a));
      push(16'h0000); check("reset_tc",    16'(tc_a));
      push(16'h000E); check("reset_sa",    16'(sa_a));
      push(16'h00C0); check("reset_led",   16'(led_a));
      push(16'h00C0); check("reset_led_b", 16'(led_b));

      // Start: first step 4 cycles after the START edge
      reset = 1'b0; start = 1'b1;
      push(16'h0001); push(16'h0000);
      tick(1); start = 1'b0;
      check("start_run", 16'(run_a));
      check("start_count", count_a);
      push(16'h0000); tick(3); check("pre_step", count_a);
      push(16'h0001); tick(1); check("step1", count_a);
      push(16'h0002); tick(4); check("step2", count_a);

      // Up wrap 59:59 -> 00:00 with one-cycle TC
      load = 1'b1; load_val = 16'h5958;
      push(16'h5958); push(16'h0001);
      tick(1); load = 1'b0;
      check("load_5958", count_a);
      check("load_keeps_run", 16'(run_a));
      push(16'h5959); push(16'h0000);
      tick(4); check("up_5959", count_a); check("up_5959_tc", 16'(tc_a));
      push(16'h0000); push(16'h0001);
      tick(4); check("up_wrap", count_a); check("up_wrap_tc", 16'(tc_a));
      push(16'h0000); tick(1); check("up_tc_one_cycle", 16'(tc_a));
      push(16'h0001); tick(3); check("up_after_wrap", count_a);

      // Down count through 00:00, both wrap modes
      dec = 1'b1; load = 1'b1; load_val = 16'h0001;
      push(16'h0001); push(16'h0001);
      tick(1); load = 1'b0;
      check("dn_load_a", count_a); check("dn_load_b", count_b);
      push(16'h0000); push(16'h0000);
      tick(4); check("dn_0000", count_a); check("dn_0000_tc", 16'(tc_a));
      push(16'h5959); push(16'h0001); push(16'h0001);
      push(16'h0000); push(16'h0001); push(16'h0000);
      tick(4);
      check("dn_wrap_a", count_a); check("dn_wrap_tc_a", 16'(tc_a)); check("dn_wrap_run_a", 16'(run_a));
      check("dn_hold_b", count_b); check("dn_hold_tc_b", 16'(tc_b)); check("dn_hold_run_b", 16'(run_b));
      push(16'h0000); tick(1); check("dn_tc_one_cycle_b", 16'(tc_b));
      push(16'h0000); push(16'h0000); push(16'h5958);
      tick(3);
      check("dn_held_b", count_b); check("dn_stopped_b", 16'(run_b)); check("dn_cont_a", count_a);

      // Clamp on load
      load = 1'b1; load_val = 16'hFA7C;
      push(16'h5959); push(16'h5959);
      tick(1); load = 1'b0;
      check("clamp_a", count_a); check("clamp_b", count_b);

      // Scan with COUNT=0123, re-aligned by reset
      reset = 1'b1; dec = 1'b0;
      tick(2);
      reset = 1'b0; load = 1'b1; load_val = 16'h0123;
      tick(1); load = 1'b0;
      push(16'h000E); push(16'h00B0); push(16'h00B0);
      tick(1);
      check("scan0_sa", 16'(sa_a)); check("scan0_led_a", 16'(led_a)); check("scan0_led_b", 16'(led_b));
      for (int i = 0; i < 4; i++) begin
         push(scan_tbl[i].sa); push(scan_tbl[i].led_a); push(scan_tbl[i].led_b); push(scan_tbl[i].sa);
         tick(scan_tbl[i].ticks);
         check("scan_sa_a", 16'(sa_a)); check("scan_led_a", 16'(led_a));
         check("scan_led_b", 16'(led_b)); check("scan_sa_b", 16'(sa_b));
      end

      // LOAD + START + step on one edge: load wins, run toggles, prescaler cleared
      start = 1'b1; push(16'h0001);
      tick(1); start = 1'b0;
      check("run_again", 16'(run_a));
      tick(3);
      load = 1'b1; load_val = 16'h1234; start = 1'b1;
      push(16'h1234); push(16'h0000);
      tick(1); load = 1'b0; start = 1'b0;
      check("combo_count", count_a); check("combo_run", 16'(run_a));
      push(16'h1234); tick(4); check("combo_stopped", count_a);
      start = 1'b1; push(16'h0001);
      tick(1); start = 1'b0;
      check("restart_run", 16'(run_a));
      push(16'h1234); tick(3); check("restart_pre", count_a);
      push(16'h1235); tick(1); check("restart_step", count_a);

      // START on a step edge: step executes, run toggles off
      tick(3); start = 1'b1;
      push(16'h1236); push(16'h0000);
      tick(1); start = 1'b0;
      check("start_step_count", count_a); check("start_step_run", 16'(run_a));
      push(16'h1236); tick(4); check("start_step_hold", count_a);

      // Reset on the wrapping edge suppresses TC
      load = 1'b1; load_val = 16'h5959; start = 1'b1;
      push(16'h0001);
      tick(1); load = 1'b0; start = 1'b0;
      check("pre_reset_run", 16'(run_a));
      tick(3); reset = 1'b1;
      push(16'h0000); push(16'h0000); push(16'h0000);
      tick(1); reset = 1'b0;
      check("rst_count", count_a); check("rst_tc", 16'(tc_a)); check("rst_run", 16'(run_a));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
